// File: rtl/rs_drv_pkg.sv
// rs_drv_pkg: shared types and helpers for the RS latch driver.
//   state_t   - 2-bit FSM state encoding (IDLE=0, PULSE_S=1, PULSE_R=2, GAP=3)
//   *_DEF     - default timing parameters (in clock cycles)
//   BTN_*     - lane index of each button in the debouncer array
//   cnt_w()   - counter width able to hold 0..max_val
//   max2()    - larger of two integers, used to size the shared phase counter
package rs_drv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    GAP     = 2'd3
  } state_t;

  localparam int DEB_CYCLES_DEF   = 4;
  localparam int PULSE_CYCLES_DEF = 2;
  localparam int GAP_CYCLES_DEF   = 1;

  localparam int BTN_SET = 0;
  localparam int BTN_RST = 1;
  localparam int NUM_BTN = 2;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rs_latch_driver_if.sv
// rs_latch_driver_if: pushbutton inputs and latch drive outputs of the
// RS latch driver.
//   SET_BTN, RST_BTN - raw asynchronous buttons, active high
//   S, R             - registered latch set/reset drive
//   BUSY             - pulse or dead time in progress
//   Q_FB, ERR        - latch feedback and sticky mismatch flag, present only
//                      when RS_VERIFY_EN is defined
// Modports: master = the driver, slave = buttons/latch side.
interface rs_latch_driver_if;

  logic SET_BTN;
  logic RST_BTN;
  logic S;
  logic R;
  logic BUSY;

`ifdef RS_VERIFY_EN
  logic Q_FB;
  logic ERR;

  modport master (
    input  SET_BTN, RST_BTN, Q_FB,
    output S, R, BUSY, ERR
  );

  modport slave (
    output SET_BTN, RST_BTN, Q_FB,
    input  S, R, BUSY, ERR
  );
`else
  modport master (
    input  SET_BTN, RST_BTN,
    output S, R, BUSY
  );

  modport slave (
    output SET_BTN, RST_BTN,
    input  S, R, BUSY
  );
`endif

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer, counter debouncer and press detector
// for one raw pushbutton.
//   CLK   - system clock, rising edge
//   RST_L - asynchronous active-low reset
//   btn   - raw asynchronous button level
//   rise  - one-cycle strobe in the cycle the debounced level flips 0->1
// The debounced level flips after DEB_CYCLES consecutive cycles in which the
// synchronized input disagrees with it; any agreement restarts the count.
module btn_debounce
  import rs_drv_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST_L,
  input  logic btn,
  output logic rise
);

  localparam int              CNT_W    = cnt_w(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             flip;

  // The counter stops at CNT_LAST: reaching it with disagreement still
  // present flips the level and returns the counter to zero.
  assign flip = (sync2_reg != level_reg) && (cnt_reg == CNT_LAST);

  // Strobe is taken from the flip condition itself so the press reaches the
  // pending flag on the same edge the level changes.
  assign rise = flip && sync2_reg;

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (flip) begin
        level_reg <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_latch_driver.sv
// rs_latch_driver: drives the R/S inputs of a NOR RS latch from two raw
// pushbuttons. Each debounced press becomes one PULSE_CYCLES-wide pulse on S
// or R, every pulse is followed by GAP_CYCLES of dead time, and R and S are
// never high together.
//   CLK   - system clock, rising edge
//   RST_L - asynchronous active-low reset
//   bus   - rs_latch_driver_if.master (SET_BTN, RST_BTN in; S, R, BUSY out;
//           Q_FB in and ERR out with RS_VERIFY_EN)
// Optional feature macro: RS_VERIFY_EN - checks synchronized Q_FB in the last
// dead cycle after each pulse and raises sticky ERR on a mismatch.
module rs_latch_driver
  import rs_drv_pkg::*;
#(
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int GAP_CYCLES   = GAP_CYCLES_DEF
) (
  input  logic              CLK,
  input  logic              RST_L,
  rs_latch_driver_if.master bus
);

  localparam int              PH_W       = cnt_w(max2(PULSE_CYCLES, GAP_CYCLES));
  localparam logic [PH_W-1:0] PULSE_LAST = PH_W'(PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0] GAP_LAST   = PH_W'(GAP_CYCLES - 1);

  if (DEB_CYCLES < 1 || PULSE_CYCLES < 1 || GAP_CYCLES < 1) begin : g_param_chk
    $error("rs_latch_driver: DEB_CYCLES, PULSE_CYCLES and GAP_CYCLES must be >= 1");
  end

  // ---------------------------------------------------------------------
  // Button front ends
  // ---------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;

  assign btn_raw[BTN_SET] = bus.SET_BTN;
  assign btn_raw[BTN_RST] = bus.RST_BTN;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .CLK  (CLK),
      .RST_L(RST_L),
      .btn  (btn_raw[gi]),
      .rise (press[gi])
    );
  end

  // ---------------------------------------------------------------------
  // Pending flags and dispatch
  // ---------------------------------------------------------------------
  state_t          state_reg;
  logic [PH_W-1:0] ph_cnt_reg;
  logic            s_reg;
  logic            r_reg;
  logic            busy_reg;
  logic            pend_s_reg;
  logic            pend_r_reg;
  logic            pend_s_next;
  logic            pend_r_next;
  logic            pulse_done;
  logic            gap_done;
  logic            dispatch;
  logic            take_s;
  logic            take_r;
  logic            set_s;
  logic            set_r;

  assign pulse_done = ((state_reg == PULSE_S) || (state_reg == PULSE_R)) &&
                      (ph_cnt_reg == PULSE_LAST);
  assign gap_done   = (state_reg == GAP) && (ph_cnt_reg == GAP_LAST);

  // The last dead cycle dispatches directly, so queued pulses are separated
  // by exactly GAP_CYCLES rather than GAP_CYCLES plus an idle cycle.
  assign dispatch = (state_reg == IDLE) || gap_done;
  assign take_r   = dispatch && pend_r_reg;
  assign take_s   = dispatch && !pend_r_reg && pend_s_reg;

  // A press on the channel currently pulsing merges into that pulse; a set
  // press arriving together with a reset press is dropped.
  assign set_r = press[BTN_RST] && (state_reg != PULSE_R);
  assign set_s = press[BTN_SET] && !press[BTN_RST] && (state_reg != PULSE_S);

  assign pend_r_next = take_r ? 1'b0 : (pend_r_reg | set_r);
  assign pend_s_next = take_s ? 1'b0 : (pend_s_reg | set_s);

  // ---------------------------------------------------------------------
  // FSM with registered outputs: S/R/BUSY are loaded with the decode of the
  // state being entered, so they are clean flop outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state_reg  <= IDLE;
      ph_cnt_reg <= '0;
      s_reg      <= 1'b0;
      r_reg      <= 1'b0;
      busy_reg   <= 1'b0;
      pend_s_reg <= 1'b0;
      pend_r_reg <= 1'b0;
    end else begin
      pend_s_reg <= pend_s_next;
      pend_r_reg <= pend_r_next;
      case (state_reg)
        PULSE_S, PULSE_R: begin
          if (pulse_done) begin
            state_reg  <= GAP;
            ph_cnt_reg <= '0;
            s_reg      <= 1'b0;
            r_reg      <= 1'b0;
          end else begin
            ph_cnt_reg <= ph_cnt_reg + 1'b1;
          end
        end
        default: begin
          if ((state_reg == GAP) && !gap_done) begin
            ph_cnt_reg <= ph_cnt_reg + 1'b1;
          end else if (take_r) begin
            state_reg  <= PULSE_R;
            ph_cnt_reg <= '0;
            r_reg      <= 1'b1;
            s_reg      <= 1'b0;
            busy_reg   <= 1'b1;
          end else if (take_s) begin
            state_reg  <= PULSE_S;
            ph_cnt_reg <= '0;
            s_reg      <= 1'b1;
            r_reg      <= 1'b0;
            busy_reg   <= 1'b1;
          end else begin
            state_reg  <= IDLE;
            ph_cnt_reg <= '0;
            s_reg      <= 1'b0;
            r_reg      <= 1'b0;
            busy_reg   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.S    = s_reg;
  assign bus.R    = r_reg;
  assign bus.BUSY = busy_reg;

`ifdef RS_VERIFY_EN
  // ---------------------------------------------------------------------
  // Latch feedback check
  // ---------------------------------------------------------------------
  if (GAP_CYCLES < 3) begin : g_gap_chk
    $error("rs_latch_driver: RS_VERIFY_EN needs GAP_CYCLES >= 3 to cover Q_FB sync latency");
  end

  logic q_sync1_reg;
  logic q_sync2_reg;
  logic last_s_reg;
  logic err_reg;

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      q_sync1_reg <= 1'b0;
      q_sync2_reg <= 1'b0;
      last_s_reg  <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      q_sync1_reg <= bus.Q_FB;
      q_sync2_reg <= q_sync1_reg;
      // Remember which pulse was issued; the gap that follows checks it.
      if (take_s) begin
        last_s_reg <= 1'b1;
      end else if (take_r) begin
        last_s_reg <= 1'b0;
      end
      if (gap_done && (q_sync2_reg != last_s_reg)) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign bus.ERR = err_reg;
`endif

endmodule
